wb_stage: RTL and testbench

- Write-back stage of the RV32E pipeline; drives the decode-stage write-back interface (wb_rd_addr / wb_data / wb_reg_write) and the register-file write port.
- Accepts retiring instructions from the memory stage over a valid/ready handshake.
- Waits for data-memory load responses, then aligns and sign- or zero-extends the load data.
- Selects the write-back source and presents one registered write per instruction.

---
 rtl/wb_stage.sv | 218 +++++++++++++++++++++
 tb/tb_wb_stage.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// wb_stage: write-back stage of the RV32E pipeline.
// Accepts retiring instructions, waits for load responses, extracts and
// extends load data, and presents one registered register-file write.
// Optional feature: define WB_RETIRE_COUNTER_EN to add the retired_count output.
module wb_stage #(
  parameter int unsigned LOAD_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_rd_addr,
  input  logic        in_reg_write,
  input  logic [1:0]  in_wb_sel,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_alu_result,
  input  logic [31:0] in_pc_plus4,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic [3:0]  wb_rd_addr,
  output logic [31:0] wb_data,
  output logic        wb_reg_write,
  output logic        misalign_err,
`ifdef WB_RETIRE_COUNTER_EN
  output logic [31:0] retired_count,
`endif
  output logic        load_err
);

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } state_e;

  // Last counter value before a pending load is abandoned.
  localparam logic [7:0] TMO_LAST = 8'(LOAD_TIMEOUT - 1);

  // Access is misaligned when the address is not a multiple of the access size.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    logic r;
    case (f3)
      3'b000, 3'b100: r = 1'b0;
      3'b001, 3'b101: r = a[0];
      default:        r = (a != 2'b00);
    endcase
    return r;
  endfunction

  // Pick the byte/halfword out of the response word and extend it.
  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] a,
                                               input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (a)
      2'b00:   b = w[7:0];
      2'b01:   b = w[15:8];
      2'b10:   b = w[23:16];
      2'b11:   b = w[31:24];
      default: b = w[7:0];
    endcase
    if (a[1]) begin
      h = w[31:16];
    end else begin
      h = w[15:0];
    end
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'h000000, b};
      3'b101:  r = {16'h0000, h};
      default: r = w;
    endcase
    return r;
  endfunction

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  ld_rd_q, ld_rd_d;
  logic        ld_we_q, ld_we_d;
  logic [2:0]  ld_f3_q, ld_f3_d;
  logic [1:0]  ld_addr_q, ld_addr_d;
  logic        ld_bad_q, ld_bad_d;
  logic [3:0]  wb_rd_addr_q, wb_rd_addr_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        wb_reg_write_q, wb_reg_write_d;
  logic        misalign_err_q, misalign_err_d;
  logic        load_err_q, load_err_d;

  assign in_ready     = (state_q == IDLE);
  assign wb_rd_addr   = wb_rd_addr_q;
  assign wb_data      = wb_data_q;
  assign wb_reg_write = wb_reg_write_q;
  assign misalign_err = misalign_err_q;
  assign load_err     = load_err_q;

  // Next-state, load bookkeeping and write-back selection.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    ld_rd_d        = ld_rd_q;
    ld_we_d        = ld_we_q;
    ld_f3_d        = ld_f3_q;
    ld_addr_d      = ld_addr_q;
    ld_bad_d       = ld_bad_q;
    wb_rd_addr_d   = wb_rd_addr_q;
    wb_data_d      = wb_data_q;
    wb_reg_write_d = 1'b0;
    misalign_err_d = 1'b0;
    load_err_d     = load_err_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (in_wb_sel == 2'b01) begin
            ld_rd_d        = in_rd_addr;
            ld_we_d        = in_reg_write;
            ld_f3_d        = in_funct3;
            ld_addr_d      = in_alu_result[1:0];
            ld_bad_d       = is_misaligned(in_funct3, in_alu_result[1:0]);
            misalign_err_d = is_misaligned(in_funct3, in_alu_result[1:0]);
            cnt_d          = 8'd0;
            state_d        = WAIT_LOAD;
          end else begin
            wb_rd_addr_d   = in_rd_addr;
            wb_reg_write_d = in_reg_write & (in_rd_addr != 4'd0);
            if (in_wb_sel == 2'b10) begin
              wb_data_d = in_pc_plus4;
            end else begin
              wb_data_d = in_alu_result;
            end
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_LOAD: begin
        if (dmem_rvalid) begin
          // A response on the timeout cycle still completes normally.
          wb_rd_addr_d   = ld_rd_q;
          wb_data_d      = load_extract(ld_f3_q, ld_addr_q, dmem_rdata);
          wb_reg_write_d = ld_we_q & (ld_rd_q != 4'd0) & ~ld_bad_q;
          state_d        = IDLE;
        end else if (cnt_q == TMO_LAST) begin
          load_err_d = 1'b1;
          cnt_d      = 8'd0;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // State and output registers; reset drops any pending load at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= 8'd0;
      ld_rd_q        <= 4'd0;
      ld_we_q        <= 1'b0;
      ld_f3_q        <= 3'd0;
      ld_addr_q      <= 2'd0;
      ld_bad_q       <= 1'b0;
      wb_rd_addr_q   <= 4'd0;
      wb_data_q      <= 32'd0;
      wb_reg_write_q <= 1'b0;
      misalign_err_q <= 1'b0;
      load_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      ld_rd_q        <= ld_rd_d;
      ld_we_q        <= ld_we_d;
      ld_f3_q        <= ld_f3_d;
      ld_addr_q      <= ld_addr_d;
      ld_bad_q       <= ld_bad_d;
      wb_rd_addr_q   <= wb_rd_addr_d;
      wb_data_q      <= wb_data_d;
      wb_reg_write_q <= wb_reg_write_d;
      misalign_err_q <= misalign_err_d;
      load_err_q     <= load_err_d;
    end
  end

`ifdef WB_RETIRE_COUNTER_EN
  logic [31:0] retired_count_q, retired_count_d;
  logic        retire_s;

  // An instruction completes on a non-load accept or when its load response is consumed.
  assign retire_s = ((state_q == IDLE) & in_valid & (in_wb_sel != 2'b01)) |
                    ((state_q == WAIT_LOAD) & dmem_rvalid);

  // Retirement counter increment, wrapping naturally at 32 bits.
  always_comb begin
    if (retire_s) begin
      retired_count_d = retired_count_q + 32'd1;
    end else begin
      retired_count_d = retired_count_q;
    end
  end

  // Retirement counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_count_q <= 32'd0;
    end else begin
      retired_count_q <= retired_count_d;
    end
  end

  assign retired_count = retired_count_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed + randomized bench for wb_stage with a transaction-level model.
module tb_wb_stage;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_rd_addr = 4'd0;
  logic        in_reg_write = 1'b0;
  logic [1:0]  in_wb_sel = 2'd0;
  logic [2:0]  in_funct3 = 3'd0;
  logic [31:0] in_alu_result = 32'd0;
  logic [31:0] in_pc_plus4 = 32'd0;
  logic        dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = 32'd0;
  logic [3:0]  wb_rd_addr;
  logic [31:0] wb_data;
  logic        wb_reg_write;
  logic        misalign_err;
  logic        load_err;
`ifdef WB_RETIRE_COUNTER_EN
  logic [31:0] retired_count;
`endif

  wb_stage #(.LOAD_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rd_addr(in_rd_addr), .in_reg_write(in_reg_write),
    .in_wb_sel(in_wb_sel), .in_funct3(in_funct3),
    .in_alu_result(in_alu_result), .in_pc_plus4(in_pc_plus4),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .wb_rd_addr(wb_rd_addr), .wb_data(wb_data), .wb_reg_write(wb_reg_write),
    .misalign_err(misalign_err),
`ifdef WB_RETIRE_COUNTER_EN
    .retired_count(retired_count),
`endif
    .load_err(load_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  bit          m_busy = 1'b0;
  int          m_wait = 0;
  logic [3:0]  m_rd = 4'd0;
  bit          m_we = 1'b0;
  logic [2:0]  m_f3 = 3'd0;
  logic [1:0]  m_a = 2'd0;
  bit          m_bad = 1'b0;
  logic [3:0]  exp_rd = 4'd0;
  logic [31:0] exp_data = 32'd0;
  bit          exp_we = 1'b0;
  bit          exp_mis = 1'b0;
  bit          exp_lerr = 1'b0;
  logic [31:0] exp_ret = 32'd0;

  function automatic int acc_size(input logic [2:0] f3);
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] w);
    logic [31:0] sh;
    sh = w >> (8 * int'(a));
    case (f3)
      3'd0:    return int'($signed(sh[7:0]));
      3'd1:    return int'($signed(sh[15:0]));
      3'd4:    return {24'd0, sh[7:0]};
      3'd5:    return {16'd0, sh[15:0]};
      default: return w;
    endcase
  endfunction

  // Model advances one instruction-level step per clock edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0; m_wait = 0;
      exp_rd = 4'd0; exp_data = 32'd0; exp_we = 1'b0;
      exp_mis = 1'b0; exp_lerr = 1'b0; exp_ret = 32'd0;
    end else begin
      exp_we = 1'b0;
      exp_mis = 1'b0;
      if (!m_busy) begin
        if (in_valid) begin
          if (in_wb_sel == 2'b01) begin
            m_busy = 1'b1; m_wait = 0;
            m_rd = in_rd_addr; m_we = in_reg_write; m_f3 = in_funct3;
            m_a = in_alu_result[1:0];
            m_bad = (int'(m_a) % acc_size(m_f3)) != 0;
            exp_mis = m_bad;
          end else begin
            exp_rd = in_rd_addr;
            exp_data = (in_wb_sel == 2'b10) ? in_pc_plus4 : in_alu_result;
            exp_we = in_reg_write && (in_rd_addr != 4'd0);
            exp_ret = exp_ret + 32'd1;
          end
        end
      end else if (dmem_rvalid) begin
        m_busy = 1'b0;
        exp_rd = m_rd;
        exp_data = model_load(m_f3, m_a, dmem_rdata);
        exp_we = m_we && (m_rd != 4'd0) && !m_bad;
        exp_ret = exp_ret + 32'd1;
      end else begin
        m_wait++;
        if (m_wait == TMO) begin
          m_busy = 1'b0;
          exp_lerr = 1'b1;
        end
      end
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, !m_busy});
      chk("wb_reg_write", {31'd0, wb_reg_write}, {31'd0, exp_we});
      chk("misalign_err", {31'd0, misalign_err}, {31'd0, exp_mis});
      chk("load_err", {31'd0, load_err}, {31'd0, exp_lerr});
      if (exp_we) begin
        chk("wb_rd_addr", {28'd0, wb_rd_addr}, {28'd0, exp_rd});
        chk("wb_data", wb_data, exp_data);
      end
`ifdef WB_RETIRE_COUNTER_EN
      chk("retired_count", retired_count, exp_ret);
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic op(input logic v, input logic [3:0] rd, input logic rw, input logic [1:0] sel,
                    input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] pc);
    in_valid = v; in_rd_addr = rd; in_reg_write = rw; in_wb_sel = sel;
    in_funct3 = f3; in_alu_result = alu; in_pc_plus4 = pc;
  endtask

  task automatic idle();
    op(1'b0, 4'd0, 1'b0, 2'd0, 3'd0, 32'd0, 32'd0);
  endtask

  task automatic resp(input logic v, input logic [31:0] d);
    dmem_rvalid = v; dmem_rdata = d;
  endtask

  // Run a load at addr with response word d presented in the given wait cycle.
  task automatic do_load(input logic [3:0] rd, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] d, input int delay, input logic [31:0] expd,
                         input string name);
    op(1'b1, rd, 1'b1, 2'b01, f3, addr, 32'd0);
    cyc(1);
    idle();
    for (int k = 1; k < delay; k++) begin
      chk({name, "_busy"}, {31'd0, in_ready}, 32'd0);
      cyc(1);
    end
    chk({name, "_busy"}, {31'd0, in_ready}, 32'd0);
    resp(1'b1, d);
    cyc(1);
    resp(1'b0, 32'd0);
    chk({name, "_we"}, {31'd0, wb_reg_write}, 32'd1);
    chk({name, "_rd"}, {28'd0, wb_rd_addr}, {28'd0, rd});
    chk({name, "_data"}, wb_data, expd);
    chk({name, "_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int mode;
    idle();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cmp_en = 1'b1;
    // reset values
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_we", {31'd0, wb_reg_write}, 32'd0);
    chk("rst_data", wb_data, 32'd0);
    chk("rst_rd", {28'd0, wb_rd_addr}, 32'd0);
    chk("rst_mis", {31'd0, misalign_err}, 32'd0);
    chk("rst_lerr", {31'd0, load_err}, 32'd0);

    // ALU op, JAL, ALU to x0
    op(1'b1, 4'd5, 1'b1, 2'b00, 3'd0, 32'h1234, 32'd0);
    cyc(1);
    chk("alu_we", {31'd0, wb_reg_write}, 32'd1);
    chk("alu_rd", {28'd0, wb_rd_addr}, 32'd5);
    chk("alu_data", wb_data, 32'h0000_1234);
    chk("alu_ready", {31'd0, in_ready}, 32'd1);
    op(1'b1, 4'd1, 1'b1, 2'b10, 3'd0, 32'hDEAD, 32'h104);
    cyc(1);
    chk("jal_we", {31'd0, wb_reg_write}, 32'd1);
    chk("jal_rd", {28'd0, wb_rd_addr}, 32'd1);
    chk("jal_data", wb_data, 32'h0000_0104);
    op(1'b1, 4'd0, 1'b1, 2'b00, 3'd0, 32'h55, 32'd0);
    cyc(1);
    chk("x0_we", {31'd0, wb_reg_write}, 32'd0);
    idle();

    // loads
    do_load(4'd7, 3'b000, 32'h1003, 32'h80FF_0000, 3, 32'hFFFF_FF80, "lb");
    do_load(4'd8, 3'b100, 32'h1003, 32'h80FF_0000, 3, 32'h0000_0080, "lbu");
    do_load(4'd9, 3'b001, 32'h2002, 32'h8001_7FFF, 1, 32'hFFFF_8001, "lh");

    // misaligned LW
    op(1'b1, 4'd4, 1'b1, 2'b01, 3'b010, 32'h0000_0002, 32'd0);
    cyc(1);
    idle();
    chk("mis_pulse", {31'd0, misalign_err}, 32'd1);
    chk("mis_busy", {31'd0, in_ready}, 32'd0);
    resp(1'b1, 32'hCAFE_BABE);
    cyc(1);
    resp(1'b0, 32'd0);
    chk("mis_nowe", {31'd0, wb_reg_write}, 32'd0);
    chk("mis_clear", {31'd0, misalign_err}, 32'd0);
    chk("mis_ready", {31'd0, in_ready}, 32'd1);

    // timeout, then a late response
    op(1'b1, 4'd3, 1'b1, 2'b01, 3'b010, 32'h0, 32'd0);
    cyc(1);
    idle();
    chk("tmo_busy1", {31'd0, in_ready}, 32'd0);
    cyc(TMO - 1);
    chk("tmo_busy16", {31'd0, in_ready}, 32'd0);
    chk("tmo_noerr", {31'd0, load_err}, 32'd0);
    cyc(1);
    chk("tmo_err", {31'd0, load_err}, 32'd1);
    chk("tmo_ready", {31'd0, in_ready}, 32'd1);
    chk("tmo_nowe", {31'd0, wb_reg_write}, 32'd0);
    resp(1'b1, 32'h1111_2222);
    cyc(1);
    resp(1'b0, 32'd0);
    chk("late_nowe", {31'd0, wb_reg_write}, 32'd0);
    chk("late_err", {31'd0, load_err}, 32'd1);

    // reset during WAIT_LOAD
    op(1'b1, 4'd6, 1'b1, 2'b01, 3'b010, 32'h0, 32'd0);
    cyc(1);
    idle();
    cyc(1);
    rst = 1'b1;
    #1;
    chk("arst_ready", {31'd0, in_ready}, 32'd1);
    chk("arst_lerr", {31'd0, load_err}, 32'd0);
    chk("arst_data", wb_data, 32'd0);
    chk("arst_we", {31'd0, wb_reg_write}, 32'd0);
    cyc(1);
    rst = 1'b0;

    // response on the timeout cycle wins
    do_load(4'd10, 3'b010, 32'h0, 32'h1234_5678, TMO, 32'h1234_5678, "edge");
    chk("edge_lerr", {31'd0, load_err}, 32'd0);

`ifdef WB_RETIRE_COUNTER_EN
    rst = 1'b1;
    #1;
    cyc(1);
    rst = 1'b0;
    op(1'b1, 4'd2, 1'b1, 2'b00, 3'd0, 32'h1, 32'd0);
    cyc(3);
    op(1'b1, 4'd2, 1'b1, 2'b01, 3'b010, 32'h0, 32'd0);
    cyc(1);
    idle();
    resp(1'b1, 32'h5);
    cyc(1);
    resp(1'b0, 32'd0);
    op(1'b1, 4'd2, 1'b1, 2'b01, 3'b010, 32'h0, 32'd0);
    cyc(1);
    idle();
    cyc(TMO);
    chk("ret_count", retired_count, 32'd4);
    chk("ret_lerr", {31'd0, load_err}, 32'd1);
`endif

    // randomized phase
    for (int i = 0; i < 3000; i++) begin
      mode = (i / 400) % 2;
      op(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
         2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), $urandom, $urandom);
      if (mode == 0) resp(($urandom_range(0, 99) < 40), $urandom);
      else resp(($urandom_range(0, 99) < 3), $urandom);
      if (i == 1500) rst = 1'b1;
      if (i == 1502) rst = 1'b0;
      cyc(1);
    end
    idle();
    resp(1'b0, 32'd0);
    cyc(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
